// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//
// Contents:
//   state_e   - sequencer state (ST_CLEAR while zeroing memory, ST_READY after)
//   depth_of  - number of words addressed by an AWIDTH-bit address
//
// Optional feature macro used by the register file: REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int unsigned depth_of(input int unsigned awidth);
        return 32'd1 << awidth;
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: one WIDTH x 2^AWIDTH storage bank with one write port and one
// read port. The read port is the array lookup only; the capturing register
// lives in regfile_mp so that clear-forcing and bypass muxing can sit ahead
// of it while still giving a single cycle of read latency.
//
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - contents of the addressed word (pre-write value on a write edge)
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = int'(depth_of(AWIDTH));

    // Storage has no reset; the clear sequencer in the top level zeroes it.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: general-purpose register file with one write port and RD_PORTS
// registered read ports. Each read port owns a replicated bank; every bank is
// written in lockstep. After every reset a sequencer zeroes all words, during
// which BUSY is high, user writes are dropped and read data is forced to 0.
//
// Ports:
//   CLK      - sole clock, rising edge
//   RST_N    - synchronous active-low reset
//   RD_ADDR  - packed read addresses, port i at [i*AWIDTH +: AWIDTH]
//   RD_DATA  - packed registered read data, port i at [i*WIDTH +: WIDTH]
//   WR_ADDR  - write address
//   WR_DATA  - write data
//   WR_EN    - write strobe
//   BUSY     - high while the clear sequence runs
//
// Configuration macro: REGFILE_BYPASS_EN. When defined, a read addressing the
// word being written in the same cycle returns the new data; otherwise it
// returns the old memory contents.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int AWIDTH   = 4,
    parameter int RD_PORTS = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [RD_PORTS*AWIDTH-1:0]   RD_ADDR,
    output logic [RD_PORTS*WIDTH-1:0]    RD_DATA,
    input  logic [AWIDTH-1:0]            WR_ADDR,
    input  logic [WIDTH-1:0]             WR_DATA,
    input  logic                         WR_EN,
    output logic                         BUSY
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;

    logic              bank_we;
    logic [AWIDTH-1:0] bank_waddr;
    logic [WIDTH-1:0]  bank_wdata;

    // Clear sequencer: walk every address once, then stay READY until reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + AWIDTH'(1);
            if (clr_cnt_q == '1) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The sequencer owns the shared write port while clearing, so user writes
    // in that window are simply lost rather than queued.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            bank_we    = 1'b1;
            bank_waddr = clr_cnt_q;
            bank_wdata = '0;
        end else begin
            bank_we    = WR_EN;
            bank_waddr = WR_ADDR;
            bank_wdata = WR_DATA;
        end
    end

    assign BUSY = (state_q == ST_CLEAR);

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_port
        logic [AWIDTH-1:0] rd_addr;
        logic [WIDTH-1:0]  bank_rdata;
        logic [WIDTH-1:0]  rd_data_d;
        logic [WIDTH-1:0]  rd_data_q;

        assign rd_addr = RD_ADDR[i*AWIDTH +: AWIDTH];

        regfile_bank #(
            .WIDTH  (WIDTH),
            .AWIDTH (AWIDTH)
        ) u_bank (
            .clk   (CLK),
            .we    (bank_we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .raddr (rd_addr),
            .rdata (bank_rdata)
        );

        // Output select: zero while clearing, else memory (or the in-flight
        // write data when bypass is built in and the addresses collide).
        always_comb begin
            rd_data_d = bank_rdata;
`ifdef REGFILE_BYPASS_EN
            if (state_q == ST_CLEAR) begin
                rd_data_d = '0;
            end else if (WR_EN && (rd_addr == WR_ADDR)) begin
                rd_data_d = WR_DATA;
            end
`else
            if (state_q == ST_CLEAR) begin
                rd_data_d = '0;
            end
`endif
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign RD_DATA[i*WIDTH +: WIDTH] = rd_data_q;
    end

endmodule
